// File: rtl/io_tx_port.sv
// Memory-mapped UART transmitter: store bytes land in a small FIFO and are
// sent as 8N1 frames on tx, with full/busy/overflow status for software polling.
module io_tx_port #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     tx,
    output logic                     full,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [BW-1:0]   baud, baud_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shift, shift_n;
    logic            tx_n, busy_n;
    logic [CW-1:0]   count_n;
    logic            push, pop;
    logic            unused_wdata;

    assign unused_wdata = ^wdata[WIDTH-1:8];

    // Full is judged on the pre-edge occupancy, so a same-edge pop never rescues a write.
    assign full = (count == CW'(DEPTH));
    assign push = we && !full;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata[7:0];
    end

    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    baud_n  = BAUD_LOAD;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (baud == '0) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                    baud_n    = BAUD_LOAD;
                    tx_n      = shift[0];
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            DATA: begin
                if (baud == '0) begin
                    baud_n  = BAUD_LOAD;
                    shift_n = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        tx_n      = shift[1];
                    end
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            STOP: begin
                if (baud == '0) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        baud_n  = BAUD_LOAD;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
        busy_n = (state_n != IDLE) || (count_n != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            count   <= count_n;
            busy    <= busy_n;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (we && full)
                overflow <= 1'b1;
        end
    end

endmodule
